// File: rtl/cart_mem_sequencer.sv
// -----------------------------------------------------------------------------
// cart_mem_sequencer
//
// Purpose:
//   Sits directly behind the MBC. Takes the translated cartridge address and the
//   ROM/RAM selects. Runs one timed single-byte access per request on a single
//   external asynchronous SRAM. The ROM image lives in the low region of the
//   SRAM and cartridge RAM lives at RAM_BASE. Read data is returned in a
//   register. A busy flag lets the CPU side stretch its bus cycle.
//
// Access sequence: IDLE -> SETUP (1) -> STROBE (WAIT_CYCLES) -> HOLD (1) -> IDLE.
// busy is high for exactly WAIT_CYCLES+2 cycles per access.
//
// Optional feature macro: CART_MEM_ROM_WP_EN
//   When defined, a write with sel_rom=1 is dropped: no SRAM cycle runs and
//   busy stays low. When undefined, ROM writes reach the SRAM, which the
//   loader relies on.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   oadr[20:0]           translated address from the MBC
//   sel_rom, sel_ram     MBC selects (sel_rom has priority)
//   read, write          CPU strobes; only the rising edge starts a request
//   wdata[7:0]           CPU write data
//   rdata[7:0]           read data register (8'hff after reset or an unmapped read)
//   busy                 access in progress
//   sram_adr             SRAM address
//   sram_dq_o, sram_dq_oe  SRAM write data and its pad output enable
//   sram_dq_i            SRAM read data
//   sram_ce_n, sram_oe_n, sram_we_n  SRAM strobes, active low
// -----------------------------------------------------------------------------
module cart_mem_sequencer #(
    parameter int unsigned        SRAM_AW     = 19,
    parameter int unsigned        ROM_AW      = 18,
    parameter logic [SRAM_AW-1:0] RAM_BASE    = 19'h60000,
    parameter int unsigned        WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [20:0]        oadr,
    input  logic               sel_rom,
    input  logic               sel_ram,
    input  logic               read,
    input  logic               write,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    output logic               busy,
    output logic [SRAM_AW-1:0] sram_adr,
    output logic [7:0]         sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [7:0]         sram_dq_i,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_e;

    // The STROBE counter is loaded with WAIT_CYCLES-1 and the phase ends when
    // it reaches zero, so the phase lasts exactly WAIT_CYCLES cycles.
    localparam logic [3:0] STROBE_LOAD = 4'(WAIT_CYCLES - 1);

    state_e               state_q;
    logic [3:0]           cnt_q;
    logic                 is_wr_q;
    logic                 read_q;
    logic                 write_q;
    logic [7:0]           rdata_q;
    logic                 busy_q;
    logic [SRAM_AW-1:0]   adr_q;
    logic [7:0]           dq_o_q;
    logic                 dq_oe_q;
    logic                 ce_n_q;
    logic                 oe_n_q;
    logic                 we_n_q;

    logic                 rd_edge;
    logic                 wr_edge;
    logic                 any_sel;
    logic                 wr_go;
    logic                 rd_go;
    logic                 rd_miss;
    logic [SRAM_AW-1:0]   rom_adr;
    logic [SRAM_AW-1:0]   ram_adr;
    logic [SRAM_AW-1:0]   acc_adr;
    logic                 unused_oadr;

    // Upper MBC address bits are not needed by either region.
    assign unused_oadr = ^oadr;

    assign rd_edge = read & ~read_q;
    assign wr_edge = write & ~write_q;
    assign any_sel = sel_rom | sel_ram;

    // A write edge always takes precedence, so a simultaneous read edge is
    // dropped even if the write itself turns out to be ignored.
`ifdef CART_MEM_ROM_WP_EN
    assign wr_go = wr_edge & ~sel_rom & sel_ram;
`else
    assign wr_go = wr_edge & any_sel;
`endif
    assign rd_go   = rd_edge & ~wr_edge & any_sel;
    assign rd_miss = rd_edge & ~wr_edge & ~any_sel;

    always_comb begin
        rom_adr                = '0;
        rom_adr[ROM_AW-1:0]    = oadr[ROM_AW-1:0];
        // RAM_BASE is 128 KiB aligned, so OR-ing the low 17 bits is an add.
        ram_adr                = RAM_BASE;
        ram_adr[16:0]          = RAM_BASE[16:0] | oadr[16:0];
        acc_adr                = sel_rom ? rom_adr : ram_adr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            rdata_q <= 8'hff;
            busy_q  <= 1'b0;
            adr_q   <= '0;
            dq_o_q  <= '0;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
        end else begin
            // Strobe history is tracked in every state so that a level still
            // high when the access finishes does not look like a new edge.
            read_q  <= read;
            write_q <= write;

            case (state_q)
                ST_IDLE: begin
                    if (wr_go || rd_go) begin
                        state_q <= ST_SETUP;
                        is_wr_q <= wr_go;
                        busy_q  <= 1'b1;
                        adr_q   <= acc_adr;
                        ce_n_q  <= 1'b0;
                        if (wr_go) begin
                            dq_o_q  <= wdata;
                            dq_oe_q <= 1'b1;
                        end
                    end else if (rd_miss) begin
                        rdata_q <= 8'hff;
                    end
                end

                ST_SETUP: begin
                    state_q <= ST_STROBE;
                    cnt_q   <= STROBE_LOAD;
                    if (is_wr_q) begin
                        we_n_q <= 1'b0;
                    end else begin
                        oe_n_q <= 1'b0;
                    end
                end

                ST_STROBE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_HOLD;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        // The SRAM output has settled by the end of the strobe.
                        if (!is_wr_q) begin
                            rdata_q <= sram_dq_i;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                ST_HOLD: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    ce_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdata      = rdata_q;
    assign busy       = busy_q;
    assign sram_adr   = adr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_cart_mem_sequencer.sv
module tb_cart_mem_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [20:0] oadr;
    logic        sel_rom, sel_ram, read, write;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        busy;
    logic [18:0] sram_adr;
    logic [7:0]  sram_dq_o;
    logic        sram_dq_oe;
    logic [7:0]  sram_dq_i;
    logic        sram_ce_n, sram_oe_n, sram_we_n;

    logic [7:0]  mem [0:(1<<19)-1];

    int total = 0;
    int bad   = 0;

    // monitor counters (written only by the monitor)
    int ce_low = 0, oe_low = 0, we_low = 0, busy_hi = 0, oe_drv = 0;
    int ce_starts = 0, conflict = 0, adr_chg = 0;
    logic [18:0] last_wr_adr = '0;
    logic        ce_prev = 1'b1;
    logic [18:0] adr_prev = '0;

    // snapshots (written only by the stimulus)
    int b_ce, b_oe, b_we, b_busy, b_drv, b_starts;

    always #5 clk = ~clk;

    cart_mem_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .oadr       (oadr),
        .sel_rom    (sel_rom),
        .sel_ram    (sel_ram),
        .read       (read),
        .write      (write),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .sram_adr   (sram_adr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

    // asynchronous SRAM model
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_adr] : 8'h00;

    always @(posedge clk) begin
        if (reset) begin
            mem[19'h04123] <= 8'h5a;
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            mem[sram_adr] <= sram_dq_o;
        end
    end

    always @(negedge clk) begin
        if (!sram_ce_n) ce_low++;
        if (!sram_oe_n) oe_low++;
        if (!sram_we_n) begin
            we_low++;
            last_wr_adr = sram_adr;
        end
        if (busy) busy_hi++;
        if (sram_dq_oe) oe_drv++;
        if (sram_dq_oe && !sram_oe_n) conflict++;
        if (!sram_ce_n && ce_prev) ce_starts++;
        if (!sram_ce_n && !ce_prev && sram_adr != adr_prev) adr_chg++;
        ce_prev  = sram_ce_n;
        adr_prev = sram_adr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_ce = ce_low; b_oe = oe_low; b_we = we_low;
        b_busy = busy_hi; b_drv = oe_drv; b_starts = ce_starts;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    // one request: raise strobe(s), wait for completion, release strobes
    task automatic access(input logic r, input logic w, input logic srom, input logic sram,
                          input logic [20:0] a, input logic [7:0] d);
        sel_rom = srom; sel_ram = sram; oadr = a; wdata = d;
        read = r; write = w;
        tick();
        wait_idle("access_done");
        read = 1'b0; write = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1; oadr = '0; sel_rom = 0; sel_ram = 0;
        read = 0; write = 0; wdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // reset state
        chk("rst_rdata", rdata, 8'hff);
        chk("rst_busy",  busy, 1'b0);
        chk("rst_ce",    sram_ce_n, 1'b1);
        chk("rst_oe",    sram_oe_n, 1'b1);
        chk("rst_we",    sram_we_n, 1'b1);
        chk("rst_dqoe",  sram_dq_oe, 1'b0);
        chk("rst_adr",   sram_adr, 19'h0);
        chk("rst_dqo",   sram_dq_o, 8'h00);

        // 1: ROM read
        snap();
        access(1, 0, 1, 0, 21'h04123, 8'h00);
        chk("rd_rdata", rdata, 8'h5a);
        chk("rd_ce",    ce_low - b_ce, 4);
        chk("rd_oe",    oe_low - b_oe, 2);
        chk("rd_busy",  busy_hi - b_busy, 4);
        chk("rd_we",    we_low - b_we, 0);
        chk("rd_adr",   sram_adr, 19'h04123);

        // 2: RAM write then readback
        snap();
        access(0, 1, 0, 1, 21'h1a005, 8'h3c);
        chk("wr_we",    we_low - b_we, 2);
        chk("wr_drv",   oe_drv - b_drv, 4);
        chk("wr_adr",   last_wr_adr, 19'h7a005);
        chk("wr_busy",  busy_hi - b_busy, 4);
        access(1, 0, 0, 1, 21'h1a005, 8'h00);
        chk("wr_rback", rdata, 8'h3c);

        // 3: unmapped read
        snap();
        sel_rom = 0; sel_ram = 0; oadr = 21'h00100; read = 1;
        tick();
        chk("nosel_rdata", rdata, 8'hff);
        chk("nosel_busy",  busy, 1'b0);
        tick(); tick();
        read = 0;
        tick();
        chk("nosel_ce",   ce_low - b_ce, 0);
        chk("nosel_bsy2", busy_hi - b_busy, 0);

        // 4: second edge during busy, level held afterwards
        snap();
        sel_ram = 1; oadr = 21'h1a005; read = 1;
        tick();
        read = 0;
        tick();
        read = 1;
        tick();
        wait_idle("twice_done");
        repeat (4) tick();
        read = 0;
        tick();
        chk("twice_starts", ce_starts - b_starts, 1);
        chk("twice_busy",   busy_hi - b_busy, 4);
        chk("twice_rdata",  rdata, 8'h3c);

        // 5a: read and write rise together
        snap();
        access(1, 1, 0, 1, 21'h1a006, 8'h77);
        chk("both_we",    we_low - b_we, 2);
        chk("both_oe",    oe_low - b_oe, 0);
        chk("both_rdata", rdata, 8'h3c);
        access(1, 0, 0, 1, 21'h1a006, 8'h00);
        chk("both_rback", rdata, 8'h77);

        // both selects: ROM region wins
        access(1, 0, 1, 1, 21'h04123, 8'h00);
        chk("selpri_rdata", rdata, 8'h5a);
        access(1, 0, 0, 1, 21'h1a006, 8'h00);
        chk("pre_rst_rdata", rdata, 8'h77);

        // 5b: reset during STROBE
        sel_rom = 1; sel_ram = 0; oadr = 21'h04123; read = 1;
        tick();
        tick();
        chk("mid_oe_low", sram_oe_n, 1'b0);
        reset = 1'b1;
        tick();
        chk("mid_ce",    sram_ce_n, 1'b1);
        chk("mid_oe",    sram_oe_n, 1'b1);
        chk("mid_we",    sram_we_n, 1'b1);
        chk("mid_dqoe",  sram_dq_oe, 1'b0);
        chk("mid_busy",  busy, 1'b0);
        chk("mid_rdata", rdata, 8'hff);
        reset = 1'b0; read = 0;
        tick(); tick();

        // 6: write into the ROM region
        snap();
        access(0, 1, 1, 0, 21'h02000, 8'ha5);
`ifdef CART_MEM_ROM_WP_EN
        chk("romwr_we",   we_low - b_we, 0);
        chk("romwr_busy", busy_hi - b_busy, 0);
`else
        chk("romwr_we",   we_low - b_we, 2);
        chk("romwr_adr",  last_wr_adr, 19'h02000);
        access(1, 0, 1, 0, 21'h02000, 8'h00);
        chk("romwr_rback", rdata, 8'ha5);
`endif

        chk("dq_oe_vs_oe", conflict, 0);
        chk("adr_stable",  adr_chg, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
